ddu_run_ctrl: RTL and testbench

Run-control sequencer for the DDU debug path. It conditions the raw board inputs `cont`, `step`, `inc`, `dec` and `mem`, then gates the CPU with a clock-enable: free-running, one cycle per step press, or halted. It also maintains the browse address that the DDU display reads, and a step counter shown on the LEDs. It sits between the board buttons/switches and the CPU/DDU datapath.

---
 rtl/ddu_pkg.sv | 12 +
 rtl/ddu_if.sv | 28 ++
 rtl/ddu_debounce.sv | 44 ++++
 rtl/ddu_run_ctrl.sv | 91 +++++++++
 tb/tb_ddu_run_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddu_pkg.sv
// Shared types and constants for the DDU run-control block.
package ddu_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/ddu_if.sv
// Board-side inputs and CPU/DDU-side outputs of the run controller.
interface ddu_if #(
    parameter int ADDR_W = 8
);
    import ddu_pkg::*;

    logic                  cont;
    logic                  step;
    logic                  mem;
    logic                  inc;
    logic                  dec;
    logic                  run_en;
    logic [ADDR_W-1:0]     ddu_addr;
    logic                  sel_mem;
    logic                  running;
    logic [STEP_CNT_W-1:0] step_cnt;
    state_t                state;     // FSM state, for observation only

    modport master (
        output cont, step, mem, inc, dec,
        input  run_en, ddu_addr, sel_mem, running, step_cnt, state
    );

    modport slave (
        input  cont, step, mem, inc, dec,
        output run_en, ddu_addr, sel_mem, running, step_cnt, state
    );
endinterface

// File: rtl/ddu_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer with a
// one-cycle rising-edge pulse on the accepted level.
module ddu_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/ddu_run_ctrl.sv
// Run-control sequencer: debounces board inputs, gates the CPU clock enable
// (run / single step / halt), and keeps the DDU browse address and step count.
module ddu_run_ctrl
    import ddu_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int ADDR_W    = 8
) (
    input  logic clk,
    input  logic reset,
    ddu_if.slave bus
);
    localparam int N_IN   = 5;
    localparam int I_CONT = 4;
    localparam int I_STEP = 3;
    localparam int I_MEM  = 2;
    localparam int I_INC  = 1;
    localparam int I_DEC  = 0;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] level;
    logic [N_IN-1:0] pulse;

    assign raw = {bus.cont, bus.step, bus.mem, bus.inc, bus.dec};

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        ddu_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .level (level[i]),
            .pulse (pulse[i])
        );
    end

    // Switches use the level, buttons use the pulse; the rest is left unused.
    wire unused_db = &{1'b0, level[I_STEP], level[I_INC], level[I_DEC],
                       pulse[I_CONT], pulse[I_MEM]};

    state_t                state;
    state_t                state_nxt;
    logic                  run_en_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [STEP_CNT_W-1:0] cnt_q;

    always_comb begin
        state_nxt = state;
        case (state)
            HALT: begin
                // A continuous-run request beats a simultaneous step press.
                if (level[I_CONT])       state_nxt = RUN;
                else if (pulse[I_STEP])  state_nxt = STEP;
            end
            STEP:    state_nxt = HALT;
            RUN:     if (!level[I_CONT]) state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HALT;
            run_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            run_en_q <= (state_nxt != HALT);
            if (run_en_q) cnt_q <= cnt_q + STEP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            case ({pulse[I_INC], pulse[I_DEC]})
                2'b10:   addr_q <= addr_q + ADDR_W'(1);
                2'b01:   addr_q <= addr_q - ADDR_W'(1);
                default: addr_q <= addr_q;
            endcase
        end
    end

    assign bus.run_en   = run_en_q;
    assign bus.running  = (state == RUN);
    assign bus.sel_mem  = level[I_MEM];
    assign bus.ddu_addr = addr_q;
    assign bus.step_cnt = cnt_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_ddu_run_ctrl.sv
// Self-checking bench for ddu_run_ctrl with a window-based reference model.
module tb_ddu_run_ctrl;
    import ddu_pkg::*;

    localparam int DB = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ddu_if #(.ADDR_W(AW)) bus ();

    ddu_run_ctrl #(.DB_CYCLES(DB), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Bit order of input vectors: {cont, step, mem, inc, dec}.
    logic [4:0]    m_s1, m_s2, m_st, m_pst;
    logic [4:0]    m_hist[$];
    logic          m_running, m_stepping;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_cnt;

    task automatic clr_model();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_pst = '0;
        m_hist.delete();
        m_running = 1'b0; m_stepping = 1'b0;
        m_addr = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [4:0] pls;
        logic [4:0] same;
        logic [4:0] flip;
        pls = m_st & ~m_pst;
        if (m_running || m_stepping) m_cnt = m_cnt + 16'd1;
        if (pls[1] && !pls[0]) m_addr = m_addr + 8'd1;
        else if (pls[0] && !pls[1]) m_addr = m_addr - 8'd1;
        if (m_running)        m_running  = m_st[4];
        else if (m_stepping)  m_stepping = 1'b0;
        else if (m_st[4])     m_running  = 1'b1;
        else if (pls[3])      m_stepping = 1'b1;
        m_pst = m_st;
        // A level is accepted once the last DB synchronized samples all differ from it.
        m_hist.push_back(m_s2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        same = '0;
        foreach (m_hist[j]) same = same | ~(m_hist[j] ^ m_st);
        flip = (m_hist.size() == DB) ? ~same : 5'b0;
        m_st = m_st ^ flip;
        m_s2 = m_s1;
        m_s1 = {bus.cont, bus.step, bus.mem, bus.inc, bus.dec};
    endtask

    function automatic logic [26:0] model_v();
        return {m_running | m_stepping, m_running, m_st[2], m_addr, m_cnt};
    endfunction

    function automatic logic [26:0] obs_v();
        return {bus.run_en, bus.running, bus.sel_mem, bus.ddu_addr, bus.step_cnt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        if (!reset) clr_model();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] incdec, input logic stp, input int hold, input int gap);
        bus.inc = incdec[1]; bus.dec = incdec[0]; bus.step = stp;
        repeat (hold) cyc();
        bus.inc = 1'b0; bus.dec = 1'b0; bus.step = 1'b0;
        repeat (gap) cyc();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        clr_model();
        for (int k = 0; k < 10; k++) begin
            {bus.cont, bus.step, bus.mem, bus.inc, bus.dec} = 5'($urandom);
            cyc();
            checks++;
            if (obs_v() !== 27'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want 0", k, obs_v());
            end
        end
        {bus.cont, bus.step, bus.mem, bus.inc, bus.dec} = 5'b0;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cyc();
            checks++;
            if (obs_v() !== 27'd0 || obs_v() !== model_v()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %h want 0", k, obs_v());
            end
        end
    endtask

    task automatic test_single_step();
        int pulses = 0;
        int at = -1;
        bus.step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL step_model cyc %0d got %h want %h", k, obs_v(), model_v());
            end
            if (bus.run_en) begin pulses++; at = k; end
        end
        checks++;
        if (pulses != 1 || at != 7) begin
            errors++;
            $display("FAIL step_pulse got %0d pulses at %0d want 1 at 7", pulses, at);
        end
        press(2'b00, 1'b0, 0, 12);
        checks++;
        if (bus.step_cnt !== 16'd1) begin
            errors++;
            $display("FAIL step_cnt1 got %0d want 1", bus.step_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            press(2'b00, 1'b1, $urandom_range(5, 15), 12);
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL step_press%0d got %h want %h", i, obs_v(), model_v());
            end
        end
        checks++;
        if (bus.step_cnt !== 16'd3) begin
            errors++;
            $display("FAIL step_cnt3 got %0d want 3", bus.step_cnt);
        end
    endtask

    task automatic test_bounce_run();
        int bad = 0;
        int fall_at = -1;
        bus.step = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) bus.step = ~bus.step;
            cyc();
            if (bus.run_en !== 1'b0) bad++;
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL bounce_model cyc %0d got %h want %h", k, obs_v(), model_v());
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_pulse got %0d run_en cycles want 0", bad);
        end
        press(2'b00, 1'b0, 0, 10);
        bus.cont = 1'b1;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k >= 10 && k < 75 && k % 6 == 0) bus.step = 1'($urandom_range(0, 1));
            if (k >= 75) bus.step = 1'b0;
            cyc();
            if (k >= 7 && (bus.run_en !== 1'b1 || bus.running !== 1'b1)) bad++;
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL run_model cyc %0d got %h want %h", k, obs_v(), model_v());
            end
        end
        checks++;
        if (bad != 0 || bus.step_cnt !== 16'd96) begin
            errors++;
            $display("FAIL run_hold got %0d gaps cnt %0d want 0 gaps cnt 96", bad, bus.step_cnt);
        end
        bus.cont = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (fall_at < 0 && bus.run_en === 1'b0) fall_at = k;
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL halt_model cyc %0d got %h want %h", k, obs_v(), model_v());
            end
        end
        checks++;
        if (fall_at != 7) begin
            errors++;
            $display("FAIL run_fall got cycle %0d want 7", fall_at);
        end
    endtask

    task automatic test_addr_wrap();
        reset = 1'b0;
        clr_model();
        repeat (2) cyc();
        reset = 1'b1;
        press(2'b01, 1'b0, 8, 10);
        checks++;
        if (bus.ddu_addr !== 8'hFF) begin
            errors++;
            $display("FAIL addr_dec_wrap got %h want ff", bus.ddu_addr);
        end
        press(2'b10, 1'b0, 8, 10);
        checks++;
        if (bus.ddu_addr !== 8'h00) begin
            errors++;
            $display("FAIL addr_inc_wrap got %h want 00", bus.ddu_addr);
        end
        press(2'b11, 1'b0, 8, 10);
        checks++;
        if (bus.ddu_addr !== 8'h00) begin
            errors++;
            $display("FAIL addr_both got %h want 00", bus.ddu_addr);
        end
        bus.mem = 1'b1;
        repeat (8) cyc();
        checks++;
        if (bus.sel_mem !== 1'b1) begin
            errors++;
            $display("FAIL sel_mem got %b want 1", bus.sel_mem);
        end
        for (int i = 0; i < 8; i++) begin
            bus.mem = 1'($urandom_range(0, 1));
            press(2'($urandom_range(1, 3)), 1'b0, $urandom_range(5, 9), $urandom_range(7, 10));
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL addr_rand%0d got %h want %h", i, obs_v(), model_v());
            end
        end
        bus.mem = 1'b0;
        bus.inc = 1'b1;
        reset = 1'b0;
        clr_model();
        repeat (3) cyc();
        reset = 1'b1;
        repeat (15) cyc();
        checks++;
        if (bus.ddu_addr !== 8'h01 || obs_v() !== model_v()) begin
            errors++;
            $display("FAIL addr_held_reset got %h want 01", bus.ddu_addr);
        end
        press(2'b00, 1'b0, 0, 10);
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int rise_at = -1;
        bus.cont = 1'b1;
        while (m_cnt != 16'd40 && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 200 || bus.step_cnt !== 16'd40 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_reach got cnt %0d running %b want 40 1", bus.step_cnt, bus.running);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        clr_model();
        #1;
        checks++;
        if ({bus.run_en, bus.running, bus.step_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL mid_run_async got run_en %b cnt %0d want 0 0", bus.run_en, bus.step_cnt);
        end
        @(negedge clk);
        repeat (2) cyc();
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (rise_at < 0 && bus.running === 1'b1) rise_at = k;
            checks++;
            if (obs_v() !== model_v()) begin
                errors++;
                $display("FAIL rerun_model cyc %0d got %h want %h", k, obs_v(), model_v());
            end
        end
        checks++;
        if (rise_at != 7) begin
            errors++;
            $display("FAIL rerun_rise got cycle %0d want 7", rise_at);
        end
        bus.cont = 1'b0;
        repeat (10) cyc();
    endtask

    initial begin
        reset = 1'b0;
        {bus.cont, bus.step, bus.mem, bus.inc, bus.dec} = 5'b0;
        clr_model();
        @(negedge clk);
        test_reset();
        test_single_step();
        test_bounce_run();
        test_addr_wrap();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
